// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states
// and the datapath mux/ALU select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13
    } state_t;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IMM   = 2'b11;

    // States that hold the memory port and wait on mem_ready.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory state and flags a timeout
// on the cycle the count would reach TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic mem_ready,
    input  logic clr,
    output logic timeout
);

    localparam int W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LASTI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [W-1:0] LAST = LASTI[W-1:0];
    localparam logic [W-1:0] CMAX = {W{1'b1}};

    logic [W-1:0] cnt;

    // Fires during the TIMEOUT-th stalled cycle; a ready in that cycle wins.
    assign timeout = (TIMEOUT != 0) && en && !mem_ready && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (!en || mem_ready || clr || timeout)
            cnt <= '0;
        else if (cnt != CMAX)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS sequencing FSM: drives ALU, register file and the unified
// memory port per state, with a memory ready handshake and timeout abort.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       jal,
    output logic       signext,
    output logic       shiftl16,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       bus_err
);

    state_t st, nx;
    logic   tmo;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .en        (is_mem_wait(st)),
        .mem_ready (mem_ready),
        .clr       (nx != st),
        .timeout   (tmo)
    );

    assign state   = st;
    assign bus_err = tmo & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= S_FETCH;
        else        st <= nx;
    end

    always_comb begin
        nx       = st;
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_RT;
        pcsrc    = PC_ALU;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        jal      = 1'b0;
        signext  = 1'b0;
        shiftl16 = 1'b0;
        aluop    = ALU_ADD;
        case (st)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                // On timeout the fetch simply retries in place.
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    nx      = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_BRIMM;
                signext = 1'b1;
                case (op)
                    OP_LW, OP_SW:     nx = S_MEMADR;
                    OP_RTYPE:         nx = (funct == FN_JR) ? S_JR : S_RTYPEEX;
                    OP_BEQ, OP_BNE:   nx = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_LUI: nx = S_IMMEX;
                    OP_J:             nx = S_JUMP;
                    OP_JAL:           nx = S_JAL;
                    default:          nx = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                signext = 1'b1;
                nx      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nx = S_MEMWB;
                else if (tmo)  nx = S_FETCH;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                nx       = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready || tmo) nx = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALU_FUNCT;
                nx      = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                nx       = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                pcen    = (op == OP_BNE) ? ~zero : zero;
                nx      = S_FETCH;
            end
            S_IMMEX: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                aluop    = (op == OP_ADDI || op == OP_ADDIU) ? ALU_ADD : ALU_IMM;
                signext  = !(op == OP_ANDI || op == OP_ORI);
                shiftl16 = (op == OP_LUI);
                nx       = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                nx       = S_FETCH;
            end
            S_JUMP: begin
                pcsrc = PC_JUMP;
                pcen  = 1'b1;
                nx    = S_FETCH;
            end
            S_JAL: begin
                pcsrc    = PC_JUMP;
                pcen     = 1'b1;
                regwrite = 1'b1;
                jal      = 1'b1;
                nx       = S_FETCH;
            end
            S_JR: begin
                pcsrc = PC_RS;
                pcen  = 1'b1;
                nx    = S_FETCH;
            end
            default: nx = S_FETCH;
        endcase
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle sequencing FSM for the MIPS core. It replaces the single-cycle `maindec` decode path with a per-instruction state machine. The block drives the shared ALU, the register file and a single unified memory port across several cycles per instruction. It waits on a memory ready handshake and flags a bus error when that handshake times out. It sits beside `aludec` inside the controller and drives the multicycle datapath's enables and multiplexer selects.

## Interface
Parameters:
- TIMEOUT, 15: maximum number of consecutive cycles a memory state waits with mem_ready low before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instr[31:26], taken from the instruction register.
- funct  in  6  instr[5:0], used to detect jr (op 000000, funct 001000).
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- memread, memwrite  out  1  memory strobes.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register load.
- pcen  out  1  PC write enable; already includes the branch condition.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = ext/shifted imm, 11 = imm<<2.
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- regwrite, regdst, memtoreg, jal  out  1  register-file write controls, with the same meaning as in the single-cycle core.
- signext, shiftl16  out  1  immediate extension controls.
- aluop  out  2  to `aludec`: 00 = add, 01 = sub, 10 = funct, 11 = immediate-op decode.
- state  out  4  current state, for debug.
- bus_err  out  1  one-cycle pulse on a memory timeout.

## Operation
State encoding and per-state behaviour (every output not listed is 0):
- FETCH=0: memread, alusrcb=01. When mem_ready is high, also irwrite and pcen with pcsrc=00, then go to DECODE. Otherwise stay in FETCH.
- DECODE=1: alusrcb=11, signext=1, which computes the branch target into ALUOut. Next state by op:
  - lw/sw → MEMADR.
  - R-type → RTYPEEX, or JR if funct=001000.
  - beq/bne → BRANCH.
  - addi/addiu/slti/sltiu/andi/ori/lui → IMMEX.
  - j → JUMP; jal → JAL.
  - any other opcode → FETCH, treated as a NOP.
- MEMADR=2: alusrca, alusrcb=10, signext. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD=3: memread, iord. Go to MEMWB when mem_ready is high; otherwise hold.
- MEMWB=4: regwrite, memtoreg; then FETCH.
- MEMWR=5: memwrite, iord. Go to FETCH when mem_ready is high; otherwise hold.
- RTYPEEX=6: alusrca, aluop=10; then RTYPEWB.
- RTYPEWB=7: regwrite, regdst; then FETCH.
- BRANCH=8: alusrca, aluop=01, pcsrc=01. pcen = zero for beq, ~zero for bne. Then FETCH.
- IMMEX=9: alusrca, alusrcb=10. aluop=00 for addi/addiu, 11 otherwise. signext=0 for andi/ori, 1 otherwise. shiftl16=1 for lui. Then IMMWB.
- IMMWB=10: regwrite; then FETCH.
- JUMP=11: pcsrc=10, pcen; then FETCH.
- JAL=12: pcsrc=10, pcen, regwrite, jal (r31 ← PC, which already holds PC+4); then FETCH.
- JR=13: pcsrc=11, pcen; then FETCH.
- Encodings 14–15 are unreachable and recover to FETCH.

Outputs are a Moore function of state, plus op, funct, zero and mem_ready where noted above.

Memory wait counter:
- Increments each cycle the FSM is in FETCH, MEMRD or MEMWR with mem_ready low.
- Clears on mem_ready or on any state change.
- When the count reaches TIMEOUT (TIMEOUT ≠ 0):
  - bus_err pulses for one cycle and the counter clears.
  - MEMRD/MEMWR abort to FETCH with no register write.
  - FETCH stays in FETCH and retries.
- The counter saturates and never wraps.

## Timing
- Reset asserted: state = FETCH, counter = 0, bus_err = 0. All strobes follow FETCH decode: memread=1, alusrcb=01, all else 0.
- Cycles per instruction with mem_ready tied high:
  - lw 5; sw 4; R-type 4; immediate ops 4.
  - beq/bne 3; j 3; jal 3; jr 3.
- Each cycle of mem_ready low in a memory state adds one cycle.
- pcen and regwrite are never asserted in the same cycle as a deasserted mem_ready in FETCH.
- Reset mid-instruction aborts immediately to FETCH; no partial writes follow deassertion.
- mem_ready high in the same cycle the timeout is reached: the access completes, and there is no bus_err.

## Structure
- A shared package `mips_pkg` holds:
  - the opcode and funct localparams;
  - the state encodings;
  - the alusrcb, pcsrc and aluop encodings.
- One sub-module, `mem_wait_timer`: the counter plus timeout compare, parameterised by TIMEOUT, width $clog2(TIMEOUT+1).

## Test plan
- Reset low mid-MEMRD → state=0, memread=1, irwrite=0, bus_err=0 while low; normal fetch resumes after release.
- lw (op 100011), mem_ready high → states 0,1,2,3,4; regwrite with memtoreg only in state 4; 5 cycles total.
- beq with zero=1, then bne with zero=1 → pcen=1 with pcsrc=01 for beq; pcen=0 for bne; both return to FETCH after 3 cycles.
- ori (op 001101) → signext=0, aluop=11 in IMMEX; lui (op 001111) → shiftl16=1; regwrite in IMMWB.
- jal, then jr (op 0, funct 001000) → JAL asserts regwrite, jal, pcsrc=10; JR asserts pcsrc=11 with pcen and no regwrite.
- sw with mem_ready held low for 15 cycles (TIMEOUT=15) → bus_err pulses exactly once, FSM goes to FETCH, and memwrite has been high for 15 cycles. With mem_ready low for 14 cycles and then high → no bus_err.
